// File: rtl/ps2_host_tx_if.sv
// Byte handshake between the bus wrapper (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       done_o;
    logic       err_o;

    modport master (output data_i, valid_i, input ready_o, done_o, err_o);
    modport slave  (input data_i, valid_i, output ready_o, done_o, err_o);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits
// plus odd parity on device clock falls, then collect the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_host_tx_if.slave bus,
    input  logic         kclk_i,
    input  logic         kdata_i,
    output logic         kclk_oe_o,
    output logic         kdata_oe_o
);
    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state;
    logic [1:0]    kclk_sync, kdata_sync;
    logic          kclk_prev;
    logic          kclk_s, kdata_s, fall;
    logic [7:0]    shreg;
    logic          parity;
    logic          err_flag;
    logic [3:0]    bitcnt;
    logic [CW-1:0] cnt, cnt_inc;
    logic          done_q, err_q;

    assign kclk_s  = kclk_sync[1];
    assign kdata_s = kdata_sync[1];
    assign fall    = kclk_prev & ~kclk_s;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    assign bus.ready_o = (state == IDLE) & ~rst_i;
    assign bus.done_o  = done_q;
    assign bus.err_o   = err_q;

    // Idle bus level is high, so the synchronisers reset high to avoid a phantom fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kclk_sync  <= 2'b11;
            kdata_sync <= 2'b11;
            kclk_prev  <= 1'b1;
        end else begin
            kclk_sync  <= {kclk_sync[0], kclk_i};
            kdata_sync <= {kdata_sync[0], kdata_i};
            kclk_prev  <= kclk_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            kclk_oe_o  <= 1'b0;
            kdata_oe_o <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag   <= 1'b0;
            bitcnt     <= '0;
            cnt        <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    kclk_oe_o  <= 1'b0;
                    kdata_oe_o <= 1'b0;
                    if (bus.valid_i && bus.ready_o) begin
                        shreg     <= bus.data_i;
                        parity    <= ~^bus.data_i;
                        cnt       <= '0;
                        kclk_oe_o <= 1'b1;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        kdata_oe_o <= 1'b1;
                        state      <= REQ;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REQ: begin
                    // Release clock; start bit stays driven until the device clocks it.
                    kclk_oe_o <= 1'b0;
                    bitcnt    <= '0;
                    cnt       <= '0;
                    state     <= SEND;
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (cnt == TO_LAST) begin
                        kclk_oe_o  <= 1'b0;
                        kdata_oe_o <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (state == SEND && fall) begin
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt < 4'd8)
                                kdata_oe_o <= ~shreg[bitcnt[2:0]];
                            else if (bitcnt == 4'd8)
                                kdata_oe_o <= ~parity;
                            else begin
                                kdata_oe_o <= 1'b0;
                                state      <= ACK;
                            end
                        end else if (state == ACK && fall) begin
                            err_flag <= kdata_s;
                            state    <= WAIT_IDLE;
                        end else if (state == WAIT_IDLE && kclk_s && kdata_s) begin
                            done_q <= 1'b1;
                            err_q  <= err_flag;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    kclk_oe_o  <= 1'b0;
                    kdata_oe_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
